// File: rtl/imm_ext_unit_if.sv
// Request/response bundle for the immediate-extension unit.
// The unit takes the slave view; whoever feeds and drains it takes the master view.
interface imm_ext_unit_if #(
  parameter int DATA_W  = 32,
  parameter int JADDR_W = 26
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_mode;
  logic [JADDR_W-1:0] in_imm;
  logic [DATA_W-1:0]  in_pc;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic               out_mode_err;

  modport master (
    output in_valid, in_mode, in_imm, in_pc, out_ready,
    input  in_ready, out_valid, out_data, out_mode_err
  );

  modport slave (
    input  in_valid, in_mode, in_imm, in_pc, out_ready,
    output in_ready, out_valid, out_data, out_mode_err
  );
endinterface

// File: rtl/imm_ext_unit.sv
// Registered immediate extender: decodes one of six modes at push time and
// buffers the result in a 2-entry FIFO with valid/ready on both sides.
module imm_ext_unit #(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 16,
  parameter int JADDR_W = 26
) (
  input logic            clk,
  input logic            rst_n,
  imm_ext_unit_if.slave  bus_if
);
  localparam logic [DATA_W-1:0] JMASK = {DATA_W{1'b1}} << (JADDR_W + 2);

  logic [DATA_W-1:0] data_q [2];
  logic              err_q  [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic              wr_ptr_d, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_err_q, out_err_d;

  logic [IMM_W-1:0]  imm_i;
  logic [DATA_W-1:0] sext_v;
  logic [DATA_W-1:0] ext_data;
  logic              ext_err;
  logic              push, pop;

  assign imm_i  = bus_if.in_imm[IMM_W-1:0];
  assign sext_v = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};

  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (bus_if.in_mode)
      3'd0:    ext_data = sext_v;
      3'd1:    ext_data = sext_v << 2;
      3'd2:    ext_data = DATA_W'(4);
      3'd3:    ext_data = (bus_if.in_pc & JMASK) | (DATA_W'(bus_if.in_imm) << 2);
      3'd4:    ext_data = DATA_W'(imm_i);
      3'd5:    ext_data = DATA_W'(imm_i) << IMM_W;
      default: ext_err  = 1'b1;
    endcase
  end

  assign push = bus_if.in_valid  && (count_q != 2'd2);
  assign pop  = bus_if.out_ready && (count_q != 2'd0);

  // The output register is loaded with whatever will be at the head after this
  // edge; a freshly pushed entry lands at the head when its slot is the next read slot.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (!push && pop) count_d = count_q - 2'd1;
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    if (count_d != 2'd0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        out_data_d = ext_data;
        out_err_d  = ext_err;
      end else begin
        out_data_d = data_q[rd_ptr_d];
        out_err_d  = err_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        data_q[k] <= '0;
        err_q[k]  <= 1'b0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= ext_data;
        err_q[wr_ptr_q]  <= ext_err;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
    end
  end

  assign bus_if.in_ready     = (count_q != 2'd2);
  assign bus_if.out_valid    = (count_q != 2'd0);
  assign bus_if.out_data     = out_data_q;
  assign bus_if.out_mode_err = out_err_q;
endmodule

// File: tb/tb_imm_ext_unit.sv
// Scoreboard bench for imm_ext_unit: directed mode/backpressure/reset scenarios
// followed by randomized traffic, all checked against an arithmetic reference.
module tb_imm_ext_unit;
  localparam int DATA_W  = 32;
  localparam int IMM_W   = 16;
  localparam int JADDR_W = 26;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imm_ext_unit_if #(.DATA_W(DATA_W), .JADDR_W(JADDR_W)) bus_if ();

  imm_ext_unit #(.DATA_W(DATA_W), .IMM_W(IMM_W), .JADDR_W(JADDR_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus_if)
  );

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_data = '0;
  logic        last_err  = 1'b0;
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          n_pops    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the mode table evaluated with plain unsigned arithmetic.
  function automatic exp_t ref_model(input logic [2:0] m, input logic [25:0] imm, input logic [31:0] pc);
    exp_t        r;
    int unsigned i  = 32'(imm[15:0]);
    int unsigned sx = (i >= 32'h8000) ? i + 32'hFFFF_0000 : i;
    r.e = 1'b0;
    case (m)
      3'd0:    r.d = sx;
      3'd1:    r.d = sx * 4;
      3'd2:    r.d = 32'd4;
      3'd3:    r.d = (pc & 32'hF000_0000) + 32'(imm) * 4;
      3'd4:    r.d = i;
      3'd5:    r.d = i * 65536;
      default: begin r.d = 32'd0; r.e = 1'b1; end
    endcase
    return r;
  endfunction

  // Scoreboard: queue depth at each falling edge is the expected buffer count.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      sb_q.delete();
      last_data = '0;
      last_err  = 1'b0;
    end else begin
      chk("out_valid", 32'(bus_if.out_valid), 32'(sb_q.size() != 0));
      chk("in_ready",  32'(bus_if.in_ready),  32'(sb_q.size() != 2));
      if (bus_if.out_valid && sb_q.size() != 0) begin
        chk("head_data", bus_if.out_data, sb_q[0].d);
        chk("head_err",  32'(bus_if.out_mode_err), 32'(sb_q[0].e));
        last_data = sb_q[0].d;
        last_err  = sb_q[0].e;
        if (bus_if.out_ready) begin
          n_pops++;
          $display("POP #%0d data=%h err=%0b", n_pops, sb_q[0].d, sb_q[0].e);
          void'(sb_q.pop_front());
        end
      end else if (!bus_if.out_valid) begin
        chk("idle_hold_data", bus_if.out_data, last_data);
        chk("idle_hold_err",  32'(bus_if.out_mode_err), 32'(last_err));
      end
      if (bus_if.in_valid && bus_if.in_ready)
        sb_q.push_back(ref_model(bus_if.in_mode, bus_if.in_imm, bus_if.in_pc));
    end
  end

  // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
  task automatic drive(input logic [2:0] m, input logic [25:0] imm, input logic [31:0] pc);
    int n = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_mode  = m;
    bus_if.in_imm   = imm;
    bus_if.in_pc    = pc;
    @(negedge clk);
    while (!bus_if.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: in_ready stuck at 0, expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t        a_exp;
    logic        acc;
    time         t0;

    rst_n            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_mode   = 3'd0;
    bus_if.in_imm    = '0;
    bus_if.in_pc     = '0;
    bus_if.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("rst_out_data",  bus_if.out_data, 32'd0);
    chk("rst_in_ready",  32'(bus_if.in_ready), 32'd1);
    chk("rst_err",       32'(bus_if.out_mode_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(1);

    // T1: single SEXT push with one-cycle latency
    drive(3'd0, 26'h0008001, 32'h0);
    chk("t1_valid", 32'(bus_if.out_valid), 32'd1);
    chk("t1_data",  bus_if.out_data, 32'hFFFF8001);
    chk("t1_err",   32'(bus_if.out_mode_err), 32'd0);
    bus_if.out_ready = 1'b1;

    // T2/T3: mode spread under streaming
    drive(3'd1, 26'h000FFFF, 32'h0);
    chk("t2_boff", bus_if.out_data, 32'hFFFFFFFC);
    drive(3'd4, 26'h0008001, 32'h0);
    chk("t2_zext", bus_if.out_data, 32'h00008001);
    drive(3'd5, 26'h0001234, 32'h0);
    chk("t2_lui",  bus_if.out_data, 32'h12340000);
    drive(3'd2, 26'h1555555, 32'h0);
    chk("t2_four", bus_if.out_data, 32'h00000004);
    drive(3'd3, 26'h3FFFFFF, 32'hA0000010);
    chk("t3_jump", bus_if.out_data, 32'hAFFFFFFC);
    drive(3'd6, 26'h0001234, 32'hFFFFFFFF);
    chk("t3_ill_data", bus_if.out_data, 32'h0);
    chk("t3_ill_err",  32'(bus_if.out_mode_err), 32'd1);
    drive(3'd7, 26'h3FFFFFF, 32'h0);
    chk("t3_ill7_err", 32'(bus_if.out_mode_err), 32'd1);
    cycles(3);

    // T4: backpressure, third request held until a pop
    bus_if.out_ready = 1'b0;
    a_exp = ref_model(3'd0, 26'h0000111, 32'h0);
    drive(3'd0, 26'h0000111, 32'h0);
    drive(3'd4, 26'h000F222, 32'h0);
    fork
      drive(3'd5, 26'h0000333, 32'h0);
      begin
        repeat (3) @(negedge clk);
        chk("t4_full_in_ready", 32'(bus_if.in_ready), 32'd0);
        chk("t4_head_stable",   bus_if.out_data, a_exp.d);
        @(posedge clk); #1;
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
      end
    join
    cycles(3);
    bus_if.out_ready = 1'b1;
    cycles(4);

    // T5: eight back-to-back pushes, one result per cycle
    t0 = $time;
    for (int k = 0; k < 8; k++)
      drive(3'($urandom_range(0, 5)), 26'($urandom), $urandom);
    chk("t5_no_bubbles", 32'($time - t0), 32'd80);
    cycles(3);

    // T6: asynchronous reset with a full buffer
    bus_if.out_ready = 1'b0;
    drive(3'd0, 26'h0008888, 32'h0);
    drive(3'd5, 26'h000ABCD, 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(bus_if.out_valid), 32'd0);
    chk("t6_data",  bus_if.out_data, 32'd0);
    chk("t6_ready", 32'(bus_if.in_ready), 32'd1);
    chk("t6_err",   32'(bus_if.out_mode_err), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(1);
    bus_if.out_ready = 1'b1;
    drive(3'd4, 26'h0001234, 32'h0);
    chk("t6_first_after", bus_if.out_data, 32'h00001234);
    cycles(3);

    // Randomized traffic; a stalled request keeps its fields
    acc = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      bus_if.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus_if.in_valid || acc) begin
        bus_if.in_valid = ($urandom_range(0, 2) != 0);
        bus_if.in_mode  = 3'($urandom_range(0, 7));
        bus_if.in_imm   = 26'($urandom);
        bus_if.in_pc    = $urandom;
      end
      @(negedge clk);
      acc = bus_if.in_valid && bus_if.in_ready;
      @(posedge clk); #1;
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    cycles(5);
    chk("drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
